// File: rtl/alu_seq.sv
// Multi-cycle RV32I/M integer ALU: single-cycle simple ops, iterative shift-add
// multiplier and restoring divider, with valid/ready handshakes on both sides.
module alu_seq #(
   parameter int WIDTH     = 32,
   parameter int OP_WIDTH  = 5,
   parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    port_A,
   input  logic [WIDTH-1:0]    port_B,
   input  logic [OP_WIDTH-1:0] operation,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    data_out,
   output logic                zero_flag,
   output logic                lesser_flag,
   output logic                lesser_u_flag,
   output logic                greater_flag,
   output logic                busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(5'b00001);
   localparam logic [OP_WIDTH-1:0] OP_NOT    = OP_WIDTH'(5'b00010);
   localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(5'b00011);
   localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(5'b00100);
   localparam logic [OP_WIDTH-1:0] OP_CMP    = OP_WIDTH'(5'b00101);
   localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(5'b00110);
   localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(5'b00111);
   localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(5'b01000);
   localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(5'b01001);
   localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(5'b01010);
   localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(5'b01011);
   localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(5'b01100);
   localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5'b01101);
   localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(5'b01110);
   localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(5'b01111);
   localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(5'b10000);
   localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5'b10001);
   localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(5'b10010);
   localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(5'b10011);
   localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(5'b10100);
   localparam logic [OP_WIDTH-1:0] OP_PASSB  = OP_WIDTH'(5'b11000);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   zero_q, zero_d, lt_q, lt_d, ltu_q, ltu_d, gt_q, gt_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     mcand_q, mcand_d, acc_q, acc_d;
   logic [WIDTH-1:0]       mplier_q, mplier_d;
   logic [WIDTH-1:0]       rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d;
   logic                   negRes_q, negRes_d, negRem_q, negRem_d, selHigh_q, selHigh_d;

   logic                   isMul, isDiv, isRem, signA, signB, opLt, opLtu, resLoad;
   logic [WIDTH-1:0]       magA, magB, simpleRes;
   logic [SHW-1:0]         shamt;
   logic [2*WIDTH-1:0]     accNext, prodFinal;
   logic [WIDTH:0]         shifted;
   logic                   quotBit;
   logic [WIDTH-1:0]       remNext, quotNext, quotFinal, remFinal;

   assign isMul = (operation == OP_MUL) || (operation == OP_MULH) ||
                  (operation == OP_MULHU) || (operation == OP_MULHSU);
   assign isDiv = (operation == OP_DIV) || (operation == OP_REM) ||
                  (operation == OP_DIVU) || (operation == OP_REMU);
   assign isRem = (operation == OP_REM) || (operation == OP_REMU);
   assign signA = port_A[WIDTH-1] && ((operation == OP_MULH) || (operation == OP_MULHSU) ||
                                      (operation == OP_DIV) || (operation == OP_REM));
   assign signB = port_B[WIDTH-1] && ((operation == OP_MULH) ||
                                      (operation == OP_DIV) || (operation == OP_REM));
   assign magA  = signA ? -port_A : port_A;
   assign magB  = signB ? -port_B : port_B;
   assign opLt  = $signed(port_A) < $signed(port_B);
   assign opLtu = port_A < port_B;
   assign shamt = port_B[SHW-1:0];

   // Datapath for every op that finishes in the accepting cycle.
   always_comb begin
      simpleRes = '0;
      case (operation)
         OP_ADD:   simpleRes = port_A + port_B;
         OP_NOT:   simpleRes = ~port_A;
         OP_SUB,
         OP_CMP:   simpleRes = port_A - port_B;
         OP_AND:   simpleRes = port_A & port_B;
         OP_OR:    simpleRes = port_A | port_B;
         OP_XOR:   simpleRes = port_A ^ port_B;
         OP_SLL:   simpleRes = port_A << shamt;
         OP_SRL:   simpleRes = port_A >> shamt;
         OP_SRA:   simpleRes = $signed(port_A) >>> shamt;
         OP_SLT:   simpleRes = {{(WIDTH-1){1'b0}}, opLt};
         OP_SLTU:  simpleRes = {{(WIDTH-1){1'b0}}, opLtu};
         OP_PASSB: simpleRes = port_B;
         default:  simpleRes = '0;
      endcase
   end

   // One multiplier bit and one quotient bit per cycle; the finals fold in the last step.
   assign accNext   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign prodFinal = negRes_q ? -accNext : accNext;
   assign shifted   = {rem_q, quot_q[WIDTH-1]};
   assign quotBit   = shifted >= {1'b0, divisor_q};
   assign remNext   = quotBit ? WIDTH'(shifted - {1'b0, divisor_q}) : shifted[WIDTH-1:0];
   assign quotNext  = {quot_q[WIDTH-2:0], quotBit};
   assign quotFinal = negRes_q ? -quotNext : quotNext;
   assign remFinal  = negRem_q ? -remNext : remNext;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      lt_d      = lt_q;
      ltu_d     = ltu_q;
      gt_d      = gt_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      selHigh_d = selHigh_q;
      resLoad   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               lt_d  = opLt;
               ltu_d = opLtu;
               gt_d  = !opLt && (port_A != port_B);
               cnt_d = '0;
               if (isMul) begin
                  mcand_d   = {{WIDTH{1'b0}}, magA};
                  mplier_d  = magB;
                  acc_d     = '0;
                  negRes_d  = signA ^ signB;
                  selHigh_d = (operation != OP_MUL);
                  state_d   = MUL;
               end else if (isDiv) begin
                  selHigh_d = isRem;
                  if (port_B == '0) begin
                     result_d = isRem ? port_A : '1;
                     resLoad  = 1'b1;
                     state_d  = DONE;
                  end else if (signA && port_A == MIN_VAL && port_B == '1) begin
                     result_d = isRem ? '0 : MIN_VAL;
                     resLoad  = 1'b1;
                     state_d  = DONE;
                  end else begin
                     quot_d    = magA;
                     rem_d     = '0;
                     divisor_d = magB;
                     negRes_d  = signA ^ signB;
                     negRem_d  = signA;
                     state_d   = DIV;
                  end
               end else begin
                  result_d = simpleRes;
                  resLoad  = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         MUL: begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = selHigh_q ? prodFinal[2*WIDTH-1:WIDTH] : prodFinal[WIDTH-1:0];
               resLoad  = 1'b1;
               state_d  = DONE;
            end
         end
         DIV: begin
            rem_d  = remNext;
            quot_d = quotNext;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = selHigh_q ? remFinal : quotFinal;
               resLoad  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (resLoad) zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         lt_q      <= 1'b0;
         ltu_q     <= 1'b0;
         gt_q      <= 1'b0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         selHigh_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         lt_q      <= lt_d;
         ltu_q     <= ltu_d;
         gt_q      <= gt_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         selHigh_q <= selHigh_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign busy          = (state_q == MUL) || (state_q == DIV);
   assign data_out      = result_q;
   assign zero_flag     = zero_q;
   assign lesser_flag   = lt_q;
   assign lesser_u_flag = ltu_q;
   assign greater_flag  = gt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;

   localparam logic [4:0] ADD = 5'b00001, NOTA = 5'b00010, SUB = 5'b00011, MUL = 5'b00100,
                          CMP = 5'b00101, MULHU = 5'b00110, MULHSU = 5'b00111, DIV = 5'b01000,
                          REM = 5'b01001, AND_ = 5'b01010, MULH = 5'b01011, OR_ = 5'b01100,
                          XOR_ = 5'b01101, SLL = 5'b01110, SRL = 5'b01111, SRA = 5'b10000,
                          DIVU = 5'b10001, REMU = 5'b10010, SLT = 5'b10011, SLTU = 5'b10100,
                          PASSB = 5'b11000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] port_A = '0;
   logic [31:0] port_B = '0;
   logic [4:0]  operation = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] data_out;
   logic        zero_flag, lesser_flag, lesser_u_flag, greater_flag, busy;

   int testsRun = 0;
   int failCount = 0;

   alu_seq #(.WIDTH(32), .OP_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .port_A(port_A), .port_B(port_B), .operation(operation),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .zero_flag(zero_flag), .lesser_flag(lesser_flag), .lesser_u_flag(lesser_u_flag),
      .greater_flag(greater_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference results from the opcode definitions using 64-bit host arithmetic.
   function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa64, sb64, p;
      logic [63:0] up;
      int          sa, sb;
      sa64 = longint'($signed(a));
      sb64 = longint'($signed(b));
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         ADD:    return a + b;
         NOTA:   return ~a;
         SUB, CMP: return a - b;
         MUL:    return a * b;
         MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         MULH:   begin p = sa64 * sb64; up = p; return up[63:32]; end
         MULHSU: begin p = sa64 * longint'({32'd0, b}); up = p; return up[63:32]; end
         DIV:    begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return sa / sb;
         end
         REM:    begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return sa % sb;
         end
         DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
         REMU:   return (b == 0) ? a : a % b;
         AND_:   return a & b;
         OR_:    return a | b;
         XOR_:   return a ^ b;
         SLL:    return a << b[4:0];
         SRL:    return a >> b[4:0];
         SRA:    return $signed(a) >>> b[4:0];
         SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         SLTU:   return (a < b) ? 32'd1 : 32'd0;
         PASSB:  return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int refLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == MUL || op == MULH || op == MULHU || op == MULHSU) return 33;
      if (op == DIVU || op == REMU) return (b == 0) ? 1 : 33;
      if (op == DIV || op == REM) begin
         if (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
         return 33;
      end
      return 1;
   endfunction

   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int holdCycles);
      logic [31:0] expRes;
      int          expLat, lat;
      expRes = refResult(op, a, b);
      expLat = refLatency(op, a, b);
      @(negedge clk);
      checkOutput("in_ready idle", 32'(in_ready), 32'd1);
      operation = op;
      port_A    = a;
      port_B    = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid) checkOutput("busy running", 32'(busy), 32'd1);
      end while (!out_valid && lat < 100);
      checkOutput($sformatf("latency op%0d", op), 32'(lat), 32'(expLat));
      checkOutput($sformatf("data op%0d a=%h b=%h", op, a, b), data_out, expRes);
      checkOutput("zero_flag", 32'(zero_flag), 32'(expRes == 0));
      checkOutput("lesser_flag", 32'(lesser_flag), 32'($signed(a) < $signed(b)));
      checkOutput("lesser_u_flag", 32'(lesser_u_flag), 32'(a < b));
      checkOutput("greater_flag", 32'(greater_flag), 32'($signed(a) > $signed(b)));
      checkOutput("busy at done", 32'(busy), 32'd0);
      checkOutput("in_ready at done", 32'(in_ready), 32'd0);
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput("hold data", data_out, expRes);
         checkOutput("hold valid", 32'(out_valid), 32'd1);
         checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      checkOutput("valid dropped", 32'(out_valid), 32'd0);
      checkOutput("in_ready back", 32'(in_ready), 32'd1);
   endtask

   function automatic logic [31:0] pickOperand(input int mode);
      logic [31:0] specials [8];
      specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h24};
      case (mode)
         0: return specials[$urandom_range(0, 7)];
         1: return 32'($signed($urandom_range(0, 40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [4:0] opTable [22];
      logic [4:0] op;
      opTable = '{ADD, NOTA, SUB, MUL, CMP, MULHU, MULHSU, DIV, REM, AND_, MULH, OR_,
                  XOR_, SLL, SRL, SRA, DIVU, REMU, SLT, SLTU, PASSB, 5'b10110};

      #1;
      checkOutput("reset data_out", data_out, 32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset flags", {28'd0, zero_flag, lesser_flag, lesser_u_flag, greater_flag}, 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(ADD,   32'hFFFFFFFF, 32'h1, 0);
      applyStimulus(CMP,   32'hFFFFFFFB, 32'h3, 0);
      applyStimulus(MULH,  32'h80000000, 32'h2, 0);
      applyStimulus(MULHU, 32'h80000000, 32'h2, 0);
      applyStimulus(MUL,   32'd7, 32'd6, 0);
      applyStimulus(DIV,   32'hFFFFFFF9, 32'h2, 0);
      applyStimulus(REM,   32'hFFFFFFF9, 32'h2, 0);
      applyStimulus(DIVU,  32'd5, 32'd0, 0);
      applyStimulus(DIV,   32'h80000000, 32'hFFFFFFFF, 0);
      applyStimulus(REM,   32'h80000000, 32'hFFFFFFFF, 0);
      applyStimulus(SRA,   32'h80000000, 32'h24, 0);
      applyStimulus(SLL,   32'h12345678, 32'h0, 0);
      applyStimulus(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      applyStimulus(SUB,   32'd10, 32'd3, 5);

      // Abandon a long division with an asynchronous reset partway through.
      @(negedge clk);
      operation = DIV;
      port_A    = 32'h12345678;
      port_B    = 32'd3;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 checkOutput("busy mid-div", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset data_out", data_out, 32'd0);
      checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset flags", {28'd0, zero_flag, lesser_flag, lesser_u_flag, greater_flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("no output after reset", 32'(out_valid), 32'd0);
      end
      applyStimulus(ADD, 32'd100, 32'd23, 0);

      for (int n = 0; n < 250; n++) begin
         op = opTable[$urandom_range(0, 21)];
         applyStimulus(op, pickOperand($urandom_range(0, 2)), pickOperand($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle integer ALU for the RV32I/M datapath; successor to the single-cycle execute ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with compare flags.
- Simple ops complete in 1 cycle; MUL/MULH* run on an iterative shift-add engine and DIV/REM* on a restoring divider, each taking WIDTH cycles.
- Adds variable shift amounts, high-half multiply, signed/unsigned divide with RISC-V corner cases, and output back-pressure.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >=8)
OP_WIDTH, 5, opcode width
CNT_WIDTH, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept request
port_A  in  WIDTH  operand A
port_B  in  WIDTH  operand B
operation  in  OP_WIDTH  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
data_out  out  WIDTH  result
zero_flag  out  1  data_out == 0
lesser_flag  out  1  signed A < B
lesser_u_flag  out  1  unsigned A < B
greater_flag  out  1  signed A > B
busy  out  1  multi-cycle engine running

Behaviour:
- Opcodes:
  - 00001 ADD; 00010 NOT A; 00011 SUB; 00100 MUL (low half); 00101 CMP (A-B, flags only meaningful); 00110 MULHU; 00111 MULHSU (A signed, B unsigned).
  - 01000 DIV; 01001 REM; 01010 AND (bitwise); 01011 MULH; 01100 OR (bitwise); 01101 XOR.
  - 01110 SLL, 01111 SRL, 10000 SRA, each by B[$clog2(WIDTH)-1:0].
  - 10001 DIVU; 10010 REMU; 10011 SLT; 10100 SLTU (result 0/1); 11000 PASSB.
  - Any other opcode -> result 0, 1-cycle latency.
- Reset (async, rst_n=0): state IDLE; data_out=0; all flags 0; out_valid=0; busy=0; counter, accumulators and operand registers cleared. Reset during MUL/DIV abandons the operation; no output follows.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready; operands, opcode and flags are captured in that cycle.
- IDLE, accepted simple op -> DONE; result registered at the accepting edge; out_valid=1 the next cycle (latency 1).
- IDLE, accepted MUL/MULH/MULHU/MULHSU -> MUL:
  - operand magnitudes latched with sign flags; counter=0.
  - One bit per cycle: if multiplier LSB then acc += multiplicand; shift.
  - After WIDTH cycles apply sign correction to the 2*WIDTH product, select low or high half, -> DONE.
  - out_valid asserts WIDTH+1 cycles after accept.
- IDLE, accepted DIV/DIVU/REM/REMU:
  - If B==0: quotient = all ones, remainder = A; go straight to DONE (latency 1).
  - Else if signed and A==MIN and B==-1: quotient = MIN, remainder = 0; DONE (latency 1).
  - Else -> DIV: restoring division on magnitudes, one quotient bit per cycle for WIDTH cycles. Quotient sign = sA^sB; remainder sign = sA. -> DONE; latency WIDTH+1.
- busy = state is MUL or DIV.
- DONE: data_out and flags held stable while out_valid=1. If out_ready=1 -> IDLE, out_valid=0 the next cycle. No new request is accepted in the cycle out_ready is seen (in_ready=0 in DONE).
- Flags: computed from the captured operands at accept, presented with out_valid, held in DONE.
  - zero_flag is computed from the final result.
  - greater_flag = !lesser_flag && (A!=B).
- Arithmetic: ADD/SUB wrap mod 2^WIDTH, no carry output. SRA sign-fills. Shift amount 0 returns A unchanged.
- in_valid while not ready: ignored; the requester must hold until accepted.

Test Plan:
- ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept; data_out=0, zero_flag=1; in_ready back high next cycle.
- CMP A=-5 (0xFFFFFFFB), B=3 -> lesser_flag=1, greater_flag=0, lesser_u_flag=0, data_out=0xFFFFFFF8.
- MULH A=0x80000000, B=2 -> busy for 32 cycles, out_valid at cycle 33, data_out=0xFFFFFFFF; MULHU same operands -> 0x00000001; MUL 7*6 -> 42.
- DIV A=-7, B=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU A=5, B=0 -> 0xFFFFFFFF at latency 1. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- SRA A=0x80000000, B=0x24 (amount 4) -> 0xF8000000; SLL by B=0 -> A.
- Hold out_ready=0 for 5 cycles after a result -> data_out stable, in_ready=0. Assert rst_n=0 mid-DIV at cycle 10 -> all outputs 0 immediately; after release, the next ADD completes normally.
